decode_stage: RTL and testbench

ID stage of the 5-stage in-order RV32I pipeline (IF, ID, EX, MEM, WB; no forwarding). It holds the IF/ID register and decodes the opcode into the 3-bit `imm_sel` and `inst[31:7]` consumed by `immediate_generator`. It tracks in-flight destination registers and stalls fetch on RAW hazards. It inserts bubbles into EX and honours branch/jump flushes from EX.

---
 rtl/decode_stage_pkg.sv | 39 +++
 rtl/decode_stage_if.sv | 29 ++
 rtl/decode_stage_hazard_scoreboard.sv | 61 ++++++
 rtl/decode_stage.sv | 141 ++++++++++++++
 tb/tb_decode_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage and its hazard scoreboard.
package pipeline_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_J  = 3'b011,
        IMM_U  = 3'b100,
        IMM_IZ = 3'b101,
        IMM_BZ = 3'b110
    } imm_sel_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic       wen;
        logic [4:0] rd;
    } sb_slot_t;

    localparam sb_slot_t SB_EMPTY = '{wen: 1'b0, rd: 5'd0};

    // A used, nonzero source collides with an in-flight register write.
    function automatic logic sb_match(input sb_slot_t slot, input logic [4:0] rs,
                                      input logic use_rs);
        return use_rs && slot.wen && (rs != 5'd0) && (rs == slot.rd);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side inputs and EX-side outputs of the decode stage, grouped as one bundle.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            if_valid_i;
    logic [31:0]     if_inst_i;
    logic [XLEN-1:0] if_pc_i;
    logic            flush_i;
    logic            stall_o;
    logic            id_valid_o;
    logic [XLEN-1:0] id_pc_o;
    logic [24:0]     inst_o;
    logic [2:0]      imm_sel_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic            reg_wen_o;
    logic            illegal_o;

    modport slave (
        input  if_valid_i, if_inst_i, if_pc_i, flush_i,
        output stall_o, id_valid_o, id_pc_o, inst_o, imm_sel_o,
               rs1_o, rs2_o, rd_o, reg_wen_o, illegal_o
    );

    modport master (
        output if_valid_i, if_inst_i, if_pc_i, flush_i,
        input  stall_o, id_valid_o, id_pc_o, inst_o, imm_sel_o,
               rs1_o, rs2_o, rd_o, reg_wen_o, illegal_o
    );
endinterface

// File: rtl/decode_stage_hazard_scoreboard.sv
// In-flight destination tracking (EX, MEM, and WB when WB_HAZARD_EN is defined)
// with RAW comparison against the sources of the instruction in ID.
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_rs1,
    input  logic       i_use_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_use_rs2,
    input  sb_slot_t   i_issue,
    input  logic       i_flush,
    output logic       o_hazard
);

    sb_slot_t r_ex;
    sb_slot_t r_mem;
    sb_slot_t w_issue;
`ifdef WB_HAZARD_EN
    sb_slot_t r_wb;
`endif

    // A flushed ID slot always enters EX as a bubble.
    always_comb begin
        w_issue = SB_EMPTY;
        if (i_flush) begin
            w_issue = SB_EMPTY;
        end else begin
            w_issue = i_issue;
        end
    end

    // Slot chain: EX receives the issue slot, older slots shift toward WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= SB_EMPTY;
            r_mem <= SB_EMPTY;
`ifdef WB_HAZARD_EN
            r_wb  <= SB_EMPTY;
`endif
        end else begin
            r_ex  <= w_issue;
            r_mem <= r_ex;
`ifdef WB_HAZARD_EN
            r_wb  <= r_mem;
`endif
        end
    end

    // Any used source matching any live slot is a RAW hazard.
    always_comb begin
        o_hazard = sb_match(r_ex,  i_rs1, i_use_rs1) | sb_match(r_ex,  i_rs2, i_use_rs2) |
                   sb_match(r_mem, i_rs1, i_use_rs1) | sb_match(r_mem, i_rs2, i_use_rs2);
`ifdef WB_HAZARD_EN
        o_hazard = o_hazard |
                   sb_match(r_wb, i_rs1, i_use_rs1) | sb_match(r_wb, i_rs2, i_use_rs2);
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: IF/ID register, opcode decode, RAW stall and flush handling.
// Optional WB_HAZARD_EN adds a WB scoreboard slot for a non-write-through register file.
module decode_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst_n,
    decode_stage_if.slave  bus
);

    logic            r_valid;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_legal;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_writes;
    imm_sel_e   w_imm_sel;
    logic       w_hazard;
    logic       w_stall;
    logic       w_id_valid;
    logic       w_reg_wen;
    sb_slot_t   w_issue;

    assign w_opcode = r_inst[6:0];
    assign w_funct3 = r_inst[14:12];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_rd     = r_inst[11:7];

    // IF/ID register: flush beats stall, stall holds, otherwise load from fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= '0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (!w_stall) begin
            r_valid <= bus.if_valid_i;
            r_inst  <= bus.if_inst_i;
            r_pc    <= bus.if_pc_i;
        end
    end

    // Opcode decode; unknown opcodes fall through as a NOP flagged illegal.
    always_comb begin
        w_legal   = 1'b1;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_imm_sel = IMM_I;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
                if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                    w_imm_sel = IMM_IZ;
                end else begin
                    w_imm_sel = IMM_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm_sel = IMM_S;
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm_sel = IMM_B;
            end
            OPC_JAL: begin
                w_writes  = 1'b1;
                w_imm_sel = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_writes  = 1'b1;
                w_imm_sel = IMM_U;
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    hazard_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rs1     (w_rs1),
        .i_use_rs1 (r_valid & w_use_rs1),
        .i_rs2     (w_rs2),
        .i_use_rs2 (r_valid & w_use_rs2),
        .i_issue   (w_issue),
        .i_flush   (bus.flush_i),
        .o_hazard  (w_hazard)
    );

    // Flush suppresses the stall so fetch can take the redirected PC.
    always_comb begin
        w_stall    = w_hazard & ~bus.flush_i;
        w_id_valid = r_valid & ~w_hazard & ~bus.flush_i;
        w_reg_wen  = w_id_valid & w_writes & (w_rd != 5'd0);
        w_issue    = SB_EMPTY;
        if (w_id_valid) begin
            w_issue = '{wen: w_reg_wen, rd: w_rd};
        end else begin
            w_issue = SB_EMPTY;
        end
    end

    assign bus.stall_o    = w_stall;
    assign bus.id_valid_o = w_id_valid;
    assign bus.id_pc_o    = r_pc;
    assign bus.inst_o     = r_inst[31:7];
    assign bus.imm_sel_o  = w_imm_sel;
    assign bus.rs1_o      = w_rs1;
    assign bus.rs2_o      = w_rs2;
    assign bus.rd_o       = w_rd;
    assign bus.reg_wen_o  = w_reg_wen;
    assign bus.illegal_o  = r_valid & ~w_legal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode plus hand sequences for stalls, flush, reset.
module tb_decode_stage;

    localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD_X2  = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] I_NOP_X0  = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_ADD_X6  = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] I_LUI_X5  = 32'h1234_52B7; // lui  x5,0x12345
    localparam logic [31:0] I_SW      = 32'h0031_2423; // sw   x3,8(x2)
    localparam logic [31:0] I_ILL     = 32'h0000_027F; // opcode 1111111, rd field 4
    localparam logic [31:0] I_SLLI    = 32'h0032_1213; // slli x4,x4,3
`ifdef WB_HAZARD_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 2;
`endif

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        e_valid;
        logic [2:0]  e_imm;
        logic        e_wen;
        logic        e_ill;
        logic [4:0]  e_rd;
        logic [4:0]  e_lo5;
        logic [31:0] e_pc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   stall_cnt;
    vec_t tbl [8];

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.if_valid_i = v;
        bus.if_inst_i  = inst;
        bus.if_pc_i    = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_stall"},   {31'd0, bus.stall_o},    32'd0);
        chk({tag, "_idvalid"}, {31'd0, bus.id_valid_o}, 32'd0);
        chk({tag, "_wen"},     {31'd0, bus.reg_wen_o},  32'd0);
        chk({tag, "_illegal"}, {31'd0, bus.illegal_o},  32'd0);
        chk({tag, "_immsel"},  {29'd0, bus.imm_sel_o},  32'd0);
        chk({tag, "_inst"},    {7'd0, bus.inst_o},      32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, I_NOP_X0, 32'd0);

        // Power-on reset.
        @(negedge clk);
        chk_reset_outs("por");
        tick;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Row i drives fetch; its expectations describe the instruction fetched in row i-1.
        tbl[0] = '{1'b1, I_NOP_X0, 32'h100, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h000};
        tbl[1] = '{1'b1, I_ADD_X6, 32'h104, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h100};
        tbl[2] = '{1'b1, I_LUI_X5, 32'h108, 1'b1, 3'b000, 1'b1, 1'b0, 5'd6, 5'd6, 32'h104};
        tbl[3] = '{1'b1, I_SW,     32'h10C, 1'b1, 3'b100, 1'b1, 1'b0, 5'd5, 5'd5, 32'h108};
        tbl[4] = '{1'b1, I_ILL,    32'h110, 1'b1, 3'b001, 1'b0, 1'b0, 5'd8, 5'd8, 32'h10C};
        tbl[5] = '{1'b1, I_SLLI,   32'h114, 1'b1, 3'b000, 1'b0, 1'b1, 5'd4, 5'd4, 32'h110};
        tbl[6] = '{1'b0, I_NOP_X0, 32'h000, 1'b1, 3'b101, 1'b1, 1'b0, 5'd4, 5'd4, 32'h114};
        tbl[7] = '{1'b0, I_NOP_X0, 32'h000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h000};

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].inst, tbl[i].pc);
            @(negedge clk);
            chk($sformatf("row%0d_stall", i),   {31'd0, bus.stall_o},    32'd0);
            chk($sformatf("row%0d_idvalid", i), {31'd0, bus.id_valid_o}, {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d_immsel", i),  {29'd0, bus.imm_sel_o},  {29'd0, tbl[i].e_imm});
            chk($sformatf("row%0d_wen", i),     {31'd0, bus.reg_wen_o},  {31'd0, tbl[i].e_wen});
            chk($sformatf("row%0d_illegal", i), {31'd0, bus.illegal_o},  {31'd0, tbl[i].e_ill});
            chk($sformatf("row%0d_rd", i),      {27'd0, bus.rd_o},       {27'd0, tbl[i].e_rd});
            chk($sformatf("row%0d_inst_lo", i), {27'd0, bus.inst_o[4:0]}, {27'd0, tbl[i].e_lo5});
            chk($sformatf("row%0d_pc", i),      bus.id_pc_o,             tbl[i].e_pc);
            tick;
        end

        // Back-to-back RAW: add x2,x1,x1 behind addi x1.
        drive(1'b1, I_ADDI_X1, 32'h200);
        @(negedge clk);
        tick;
        drive(1'b1, I_ADD_X2, 32'h204);
        @(negedge clk);
        chk("raw_producer_nostall", {31'd0, bus.stall_o}, 32'd0);
        tick;
        stall_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.stall_o !== 1'b1) break;
            stall_cnt++;
            chk("raw_bubble", {31'd0, bus.id_valid_o}, 32'd0);
            tick;
        end
        chk("raw_stall_cycles", stall_cnt, EXP_STALL);
        chk("raw_issue",        {31'd0, bus.id_valid_o}, 32'd1);
        chk("raw_rs1",          {27'd0, bus.rs1_o}, 32'd1);
        chk("raw_rs2",          {27'd0, bus.rs2_o}, 32'd1);
        chk("raw_pc",           bus.id_pc_o, 32'h204);
        drive(1'b0, I_NOP_X0, 32'd0);
        repeat (4) tick;

        // Flush during a hazard stall.
        drive(1'b1, I_ADDI_X1, 32'h300);
        @(negedge clk);
        tick;
        drive(1'b1, I_ADD_X2, 32'h304);
        @(negedge clk);
        tick;
        @(negedge clk);
        chk("flush_pre_stall", {31'd0, bus.stall_o}, 32'd1);
        bus.flush_i = 1'b1;
        drive(1'b1, I_ADD_X6, 32'h400);
        #1;
        chk("flush_stall",   {31'd0, bus.stall_o},    32'd0);
        chk("flush_idvalid", {31'd0, bus.id_valid_o}, 32'd0);
        tick;
        bus.flush_i = 1'b0;
        drive(1'b0, I_NOP_X0, 32'd0);
        @(negedge clk);
        chk("flush_next_idvalid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("flush_next_inst",    {7'd0, bus.inst_o},     32'd0);
        chk("flush_next_stall",   {31'd0, bus.stall_o},   32'd0);
        repeat (4) tick;

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, I_ADDI_X1, 32'h500);
        @(negedge clk);
        tick;
        drive(1'b1, I_ADD_X2, 32'h504);
        @(negedge clk);
        tick;
        @(negedge clk);
        chk("rst_pre_stall", {31'd0, bus.stall_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, I_ADD_X2, 32'h600);
        chk("rst_release_idvalid", {31'd0, bus.id_valid_o}, 32'd0);
        tick;
        drive(1'b0, I_NOP_X0, 32'd0);
        @(negedge clk);
        chk("rst_first_issue", {31'd0, bus.id_valid_o}, 32'd1);
        chk("rst_first_stall", {31'd0, bus.stall_o},    32'd0);
        chk("rst_first_pc",    bus.id_pc_o,             32'h600);
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
